// File: rtl/ble_packet_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ble_packet_sync
//  Function : BLE link-layer bit receiver. Access-address correlation,
//             de-whitening, byte deserialisation and CRC24 check.
//  Revision : 1.0  initial release
// ============================================================================
module ble_packet_sync #(
  parameter int          AA_WIDTH    = 32,
  parameter int          MAX_ERR     = 1,
  parameter int          MAX_PAYLOAD = 37,
  parameter bit          WHITEN_EN   = 1'b1,
  parameter logic [23:0] CRC_INIT    = 24'h555555
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                update,
  input  logic                value,
  input  logic [AA_WIDTH-1:0] access_addr,
  input  logic [5:0]          chan_idx,
  output logic                aa_found,
  output logic [7:0]          byte_out,
  output logic                byte_valid,
  output logic [7:0]          pkt_len,
  output logic                pkt_done,
  output logic                crc_ok,
  output logic                pkt_err
);

  localparam int          CW         = $clog2(AA_WIDTH + 1);
  localparam logic [23:0] C_CRC_POLY = 24'h00065B;

  typedef enum logic [2:0] {
    S_HUNT    = 3'd0,
    S_HEADER  = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CRC     = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t              r_state;
  logic [AA_WIDTH-1:0] r_sr;
  logic [CW-1:0]       r_aa_cnt;
  logic [6:0]          r_whiten;
  logic [23:0]         r_crc;
  logic [7:0]          r_shift;
  logic [2:0]          r_bit_cnt;
  logic [7:0]          r_byte_cnt;

  logic [AA_WIDTH-1:0] w_sr_next;
  logic [CW-1:0]       w_aa_cnt_next;
  logic [CW-1:0]       w_err_cnt;
  logic                w_match;
  logic                w_d;
  logic                w_fb;
  logic [6:0]          w_whiten_next;
  logic [23:0]         w_crc_next;
  logic [7:0]          w_byte;
  logic                w_byte_done;

  always_comb begin
    w_sr_next     = {value, r_sr[AA_WIDTH-1:1]};
    w_aa_cnt_next = (r_aa_cnt == CW'(AA_WIDTH)) ? r_aa_cnt : r_aa_cnt + 1'b1;
    // Hamming distance is taken on the post-shift window so the match lands on the final bit
    w_err_cnt = '0;
    for (int i = 0; i < AA_WIDTH; i++) begin
      w_err_cnt = w_err_cnt + CW'(w_sr_next[i] ^ access_addr[i]);
    end
    w_match = (w_aa_cnt_next == CW'(AA_WIDTH)) && (w_err_cnt <= CW'(MAX_ERR));

    w_d           = value ^ (WHITEN_EN ? r_whiten[6] : 1'b0);
    w_whiten_next = {r_whiten[5], r_whiten[4], r_whiten[3] ^ r_whiten[6],
                     r_whiten[2], r_whiten[1], r_whiten[0], r_whiten[6]};
    w_fb          = r_crc[23] ^ w_d;
    w_crc_next    = {r_crc[22:0], 1'b0} ^ (w_fb ? C_CRC_POLY : 24'h0);
    w_byte        = {w_d, r_shift[7:1]};
    w_byte_done   = (r_bit_cnt == 3'd7);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_HUNT;
      r_sr       <= '0;
      r_aa_cnt   <= '0;
      r_whiten   <= '0;
      r_crc      <= '0;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
      aa_found   <= 1'b0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      pkt_len    <= '0;
      pkt_done   <= 1'b0;
      crc_ok     <= 1'b0;
      pkt_err    <= 1'b0;
    end else begin
      aa_found   <= 1'b0;
      byte_valid <= 1'b0;
      pkt_done   <= 1'b0;
      crc_ok     <= 1'b0;
      pkt_err    <= 1'b0;
      if (!en) begin
        r_state  <= S_HUNT;
        r_sr     <= '0;
        r_aa_cnt <= '0;
        byte_out <= '0;
      end else begin
        case (r_state)
          S_HUNT: begin
            if (update) begin
              if (w_match) begin
                // correlator is cleared here so every later return to HUNT starts fresh
                aa_found   <= 1'b1;
                r_state    <= S_HEADER;
                r_sr       <= '0;
                r_aa_cnt   <= '0;
                r_whiten   <= {chan_idx[0], chan_idx[1], chan_idx[2], chan_idx[3],
                               chan_idx[4], chan_idx[5], 1'b1};
                r_crc      <= CRC_INIT;
                r_bit_cnt  <= '0;
                r_byte_cnt <= '0;
              end else begin
                r_sr     <= w_sr_next;
                r_aa_cnt <= w_aa_cnt_next;
              end
            end
          end
          S_HEADER, S_PAYLOAD, S_CRC: begin
            if (update) begin
              r_whiten  <= w_whiten_next;
              r_crc     <= w_crc_next;
              r_shift   <= w_byte;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (w_byte_done) begin
                byte_out   <= w_byte;
                byte_valid <= 1'b1;
                r_byte_cnt <= r_byte_cnt + 8'd1;
                case (r_state)
                  S_HEADER: begin
                    if (r_byte_cnt == 8'd1) begin
                      pkt_len    <= w_byte;
                      r_byte_cnt <= '0;
                      if (w_byte > 8'(MAX_PAYLOAD)) begin
                        pkt_done <= 1'b1;
                        pkt_err  <= 1'b1;
                        r_state  <= S_HUNT;
                      end else if (w_byte == 8'd0) begin
                        r_state <= S_CRC;
                      end else begin
                        r_state <= S_PAYLOAD;
                      end
                    end
                  end
                  S_PAYLOAD: begin
                    if (r_byte_cnt == pkt_len - 8'd1) begin
                      r_byte_cnt <= '0;
                      r_state    <= S_CRC;
                    end
                  end
                  S_CRC: begin
                    if (r_byte_cnt == 8'd2) begin
                      r_byte_cnt <= '0;
                      r_state    <= S_DONE;
                    end
                  end
                  default: r_state <= S_HUNT;
                endcase
              end
            end
          end
          S_DONE: begin
            pkt_done <= 1'b1;
            crc_ok   <= (r_crc == 24'h0);
            r_state  <= S_HUNT;
          end
          default: r_state <= S_HUNT;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/ble_packet_sync.md
Name: ble_packet_sync

Overview:
- Bit-level BLE link-layer receiver that follows the matched-filter demodulator.
- Consumes the demodulated bit stream (value qualified by the update strobe).
- Hunts for a programmable access address with tolerated bit errors, then de-whitens the packet and deserialises header, payload and CRC bytes.
- Checks CRC24 and reports packet status; output is the byte stream the packet logic and debug capture consume.

Parameters:
- AA_WIDTH, 32: access-address correlator length in bits.
- MAX_ERR, 1: maximum Hamming distance accepted as an access-address match (0..3).
- MAX_PAYLOAD, 37: largest accepted payload length field in bytes; larger aborts the packet.
- WHITEN_EN, 1: 1 = de-whitening applied; 0 = bits pass straight through.
- CRC_INIT, 24'h555555: CRC24 register preset at header start.

Ports:
- clk  in  1  system clock (16 MHz ADC clock domain)
- rst  in  1  asynchronous, active-low reset
- en  in  1  receiver enable; low forces HUNT and clears the correlator
- update  in  1  one-clk strobe per recovered bit; minimum spacing 2 clk
- value  in  1  demodulated bit, valid when update=1
- access_addr  in  AA_WIDTH  target access address, bit 0 transmitted first
- chan_idx  in  6  RF channel index, used for whitening seed
- aa_found  out  1  one-clk pulse on access-address match
- byte_out  out  8  de-whitened byte, first received bit in bit 0
- byte_valid  out  1  one-clk pulse; byte_out valid
- pkt_len  out  8  payload length field, valid from second header byte until next aa_found
- pkt_done  out  1  one-clk pulse at end of packet or abort
- crc_ok  out  1  valid with pkt_done; 1 = CRC residue zero
- pkt_err  out  1  valid with pkt_done; 1 = length abort

Behaviour:
- Reset (rst=0, async): FSM=HUNT; correlator, whitening, CRC and bit/byte counters cleared. All outputs 0. Reset has priority over everything; mid-packet reset drops the packet with no pkt_done.
- Bits are consumed only on clk edges where update=1 and en=1. All outputs are registered.
- FSM states and transitions:
  - HUNT:
    - sr <= {value, sr[AA_WIDTH-1:1]}.
    - Valid-bit counter saturates at AA_WIDTH.
    - Match when counter == AA_WIDTH and popcount(sr ^ access_addr) <= MAX_ERR, evaluated on the shifted value.
    - aa_found pulses the clk after the matching update.
    - On match: whitening LFSR w[6:0] <= {chan_idx[0..5] order: w[1]=chan_idx[5] … w[6]=chan_idx[0], w[0]=1}; CRC <= CRC_INIT; go HEADER.
  - HEADER: 16 bits (2 bytes). Second byte latched into pkt_len.
    - If pkt_len > MAX_PAYLOAD: pkt_done=1, pkt_err=1, crc_ok=0 on the clk after the 16th bit; go HUNT.
    - Else if pkt_len == 0: go CRC.
    - Else: go PAYLOAD.
  - PAYLOAD: pkt_len*8 bits, then go CRC.
  - CRC: 24 bits, then go DONE.
  - DONE: one clk. pkt_done=1, crc_ok=(crc==0), pkt_err=0; go HUNT.
- Per bit in HEADER/PAYLOAD/CRC:
  - d = value ^ (WHITEN_EN ? w[6] : 0).
  - Whitening update: w <= {w[5:0], w[6]} with new w[4] = w[3]^w[6].
  - CRC update: fb = crc[23]^d; crc <= {crc[22:0],1'b0} ^ (fb ? 24'h00065B : 0).
  - The CRC field is also fed through the CRC, so a good packet leaves residue 0.
- Byte assembly: shift d in LSB-first. After the 8th bit of any byte (header, payload, CRC), byte_out/byte_valid update on the next clk. byte_out holds until the next byte.
- Bytes per packet = 2 + pkt_len + 3. Exactly that many byte_valid pulses per non-aborted packet. The final byte_valid and pkt_done never coincide (DONE is one clk later).
- Correlator shift register and counter are cleared on every entry to HUNT, so 32 fresh bits are needed before the next match.
- en=0 at any time: next clk go HUNT, clear correlator; no pkt_done; outputs other than pkt_len go 0.
- update asserted while en=0 is ignored.

Test Plan:
- AA 0x8E89BED6 sent LSB-first after 8 random bits, MAX_ERR=1 → aa_found exactly 1 clk after 32nd update; no pulse before.
- Same AA with 1 flipped bit → aa_found; with 2 flipped bits → no aa_found, FSM stays HUNT.
- Advertising packet on chan_idx=37, header 0x42 0x06, 6-byte payload, CRC from golden model, whitened → 11 byte_valid with bytes 0x42,0x06,payload,CRC; pkt_len=6; pkt_done with crc_ok=1, pkt_err=0.
- Same packet with one payload bit flipped → identical byte count; pkt_done with crc_ok=0.
- Header length 0x3C (60) with MAX_PAYLOAD=37 → 2 byte_valid pulses, then pkt_done with pkt_err=1 one clk after 16th header bit; next AA is still detected.
- rst low during payload byte 3 → all outputs 0 immediately, no pkt_done; a subsequent full packet decodes with crc_ok=1. en low mid-header → no pkt_done, return to HUNT.
